trace_buffer: RTL and testbench
===============================

# trace_buffer

Parametrised circular capture buffer that records one qualified processor observation word per clock (for example a packed PC, instruction, writeback register and hazard/branch flags) and freezes a window around a trigger event. It sits beside the processor in the top-level wrapper and replaces fixed per-signal debug ports with one configurable, depth-limited history that is read out afterwards. Pre-trigger history, the trigger sample and a programmable post-trigger count are kept and replayed oldest-first.

## Interface
- DATA_W, 32, width of a captured sample
- DEPTH, 64, number of buffer entries; power of two, at least 2
- ADDR_W, log2(DEPTH), derived; not overridden
- clock  in  1  master clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- sample_in  in  DATA_W  observation word
- sample_valid  in  1  qualifies sample_in this cycle (low while the processor is stalled)
- trig_in  in  1  trigger condition; counts only when sample_valid=1
- arm  in  1  single-cycle pulse; starts or restarts a capture
- post_count  in  ADDR_W  samples stored after the trigger sample (0..DEPTH-1); sampled on the trigger cycle
- rd_en  in  1  read request; acted on only in DONE
- rd_data  out  DATA_W  registered read data
- rd_valid  out  1  rd_data valid this cycle
- rd_last  out  1  rd_data is the final (newest) sample
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- count  out  ADDR_W+1  valid entries held; saturates at DEPTH
- trig_index  out  ADDR_W  readout position of the trigger sample, with 0 as the oldest

## Operation
- Storage: DEPTH x DATA_W register array, write pointer wr_ptr, read pointer rd_ptr, remaining-post counter rem.
- IDLE: no writes. arm -> ARMED with wr_ptr=0 and count=0. A trigger in the arm cycle is ignored.
- ARMED: each sample_valid cycle writes sample_in at wr_ptr, wr_ptr+1 (wrapping mod DEPTH), count=min(count+1, DEPTH). When sample_valid and trig_in are both high, the trigger sample is written, rem=post_count, and the state goes to POST, or to DONE if post_count=0.
- POST: each sample_valid cycle writes as in ARMED and decrements rem. The write made with rem=1 moves the state to DONE. trig_in is ignored. A full buffer overwrites the oldest entry. post_count<=DEPTH-1 keeps the trigger sample resident.
- Entry to DONE: rd_ptr = wr_ptr_next - count_next (mod DEPTH). trig_index = count_next - 1 - post_count (truncated to ADDR_W bits). Writes stop.
- DONE: each rd_en cycle reads the array at rd_ptr into rd_data, sets rd_valid=1 and advances rd_ptr. The read of the count-th sample also sets rd_last=1 and moves the state to IDLE. count and trig_index hold their values until the next arm.
- arm in ARMED, POST or DONE restarts the capture as from IDLE. arm has priority over any same-cycle trigger or read, and pending readout is discarded.
- rd_en outside DONE has no effect: rd_valid stays 0 and no pointer moves.
- post_count > DEPTH-1 is illegal; behaviour is undefined and the bench never drives it.

## Timing
- Reset values: state=0, count=0, trig_index=0, rd_data=0, rd_valid=0, rd_last=0, all pointers and rem=0. Array contents are don't-care.
- Reset asserted mid-capture or mid-readout: outputs take their reset values asynchronously. After release, the block waits in IDLE for arm.
- Write latency: a sample with sample_valid high at edge N is stored at edge N and counted in count after edge N.
- Trigger-to-DONE: state=3 after the edge that stores the (post_count)-th post-trigger sample, or after the trigger edge itself when post_count=0.
- Read latency: rd_en high before edge N puts the data, rd_valid and rd_last out after edge N. rd_en held high streams one word per cycle with no bubbles. The edge that produces rd_last also sets state=0, so further rd_en is ignored.
- rd_valid is a one-cycle pulse per accepted rd_en; nothing is held or repeated.

## Test plan
- DEPTH=8, post_count=1: arm; valid samples 0xA,0xB(trig),0xC -> state=3, count=3, trig_index=1; rd_en x3 -> rd_data 0xA,0xB,0xC, rd_last on 0xC, state=0 on the following cycle.
- Wrap: DEPTH=8, post_count=3, samples 1..20 with trigger on 15 -> count=8, trig_index=4; readout 11..18, rd_last on 18.
- Qualification: trig_in high while sample_valid=0, with samples 5,6 between -> no trigger and no write. A later valid trigger on 7 with post_count=0 -> count=3, trig_index=2, readout 5,6,7.
- post_count=0 and trigger on the first sample 0xFF -> state 1->3 in one edge, count=1, trig_index=0; a single read gives 0xFF with rd_last=1.
- Reset (low) in POST after 4 samples -> state/count/rd_valid read 0 immediately; rd_en after release -> no rd_valid. arm in DONE before readout -> state=1, count=0.
- rd_en held high in IDLE and ARMED -> rd_valid stays 0. rd_en held high in DONE with count=8 -> 8 consecutive rd_valid cycles, then rd_valid=0.

Source files
------------

// File: rtl/trace_buffer.sv
// Circular capture buffer: records qualified observation words, freezes a window
// around a trigger event and replays it oldest-first.
module trace_buffer #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] sample_in,
   input  logic              sample_valid,
   input  logic              trig_in,
   input  logic              arm,
   input  logic [ADDR_W-1:0] post_count,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   output logic [1:0]        state,
   output logic [ADDR_W:0]   count,
   output logic [ADDR_W-1:0] trig_index
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_POST  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e             st;
   logic [DATA_W-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0]  wr_ptr;
   logic [ADDR_W-1:0]  rd_ptr;
   logic [ADDR_W-1:0]  rem;
   logic [ADDR_W-1:0]  post_q;

   logic               write_c;
   logic [ADDR_W-1:0]  wr_ptr_nx_c;
   logic [ADDR_W:0]    count_nx_c;
   logic [ADDR_W-1:0]  start_ptr_c;

   assign state = st;

   // Writes only while capturing; a restart pulse suppresses the same-cycle write.
   assign write_c     = sample_valid && !arm && (st == S_ARMED || st == S_POST);
   assign wr_ptr_nx_c = wr_ptr + ADDR_W'(1);
   assign count_nx_c  = (count == (ADDR_W+1)'(DEPTH)) ? count : count + (ADDR_W+1)'(1);
   // Oldest entry once frozen; a full buffer gives wr_ptr_nx_c itself.
   assign start_ptr_c = wr_ptr_nx_c - ADDR_W'(count_nx_c);

   always_ff @(posedge clock) begin
      if (write_c) mem[wr_ptr] <= sample_in;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st         <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rem        <= '0;
         post_q     <= '0;
         count      <= '0;
         trig_index <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         if (arm) begin
            st         <= S_ARMED;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rem        <= '0;
            count      <= '0;
            trig_index <= '0;
         end else begin
            case (st)
               S_IDLE: ;
               S_ARMED: begin
                  if (sample_valid) begin
                     wr_ptr <= wr_ptr_nx_c;
                     count  <= count_nx_c;
                     if (trig_in) begin
                        rem    <= post_count;
                        post_q <= post_count;
                        if (post_count == '0) begin
                           st         <= S_DONE;
                           rd_ptr     <= start_ptr_c;
                           trig_index <= ADDR_W'(count_nx_c - (ADDR_W+1)'(1));
                        end else begin
                           st <= S_POST;
                        end
                     end
                  end
               end
               S_POST: begin
                  if (sample_valid) begin
                     wr_ptr <= wr_ptr_nx_c;
                     count  <= count_nx_c;
                     rem    <= rem - ADDR_W'(1);
                     if (rem == ADDR_W'(1)) begin
                        st         <= S_DONE;
                        rd_ptr     <= start_ptr_c;
                        trig_index <= ADDR_W'(count_nx_c - (ADDR_W+1)'(1)
                                              - (ADDR_W+1)'(post_q));
                     end
                  end
               end
               S_DONE: begin
                  // Newest entry sits just behind the frozen write pointer.
                  if (rd_en) begin
                     rd_data  <= mem[rd_ptr];
                     rd_valid <= 1'b1;
                     rd_ptr   <= rd_ptr + ADDR_W'(1);
                     if (rd_ptr == wr_ptr - ADDR_W'(1)) begin
                        rd_last <= 1'b1;
                        st      <= S_IDLE;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trace_buffer.sv
// Directed, table-driven bench for trace_buffer at DEPTH=8.
module tb_trace_buffer;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned ADDR_W = 3;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic              sample_valid = 1'b0;
   logic              trig_in = 1'b0;
   logic              arm = 1'b0;
   logic [ADDR_W-1:0] post_count = '0;
   logic              rd_en = 1'b0;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic [1:0]        state;
   logic [ADDR_W:0]   count;
   logic [ADDR_W-1:0] trig_index;

   int tests  = 0;
   int failed = 0;

   trace_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock        (clock),
      .reset        (reset),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .trig_in      (trig_in),
      .arm          (arm),
      .post_count   (post_count),
      .rd_en        (rd_en),
      .rd_data      (rd_data),
      .rd_valid     (rd_valid),
      .rd_last      (rd_last),
      .state        (state),
      .count        (count),
      .trig_index   (trig_index)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic              arm;
      logic              sv;
      logic [DATA_W-1:0] smp;
      logic              trig;
      logic [ADDR_W-1:0] post;
      logic              rd;
      logic [1:0]        e_state;
      logic [ADDR_W:0]   e_count;
      logic              e_rv;
      logic              e_rl;
      logic [DATA_W-1:0] e_data;
      logic              chk_ti;
      logic [ADDR_W-1:0] e_ti;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input int a, input int sv, input int smp, input int tr,
                               input int po, input int rd, input int es, input int ec,
                               input int rv, input int rl, input int ed, input int cti,
                               input int eti);
      vec_t v;
      v.arm     = 1'(a);
      v.sv      = 1'(sv);
      v.smp     = 32'(smp);
      v.trig    = 1'(tr);
      v.post    = 3'(po);
      v.rd      = 1'(rd);
      v.e_state = 2'(es);
      v.e_count = 4'(ec);
      v.e_rv    = 1'(rv);
      v.e_rl    = 1'(rl);
      v.e_data  = 32'(ed);
      v.chk_ti  = 1'(cti);
      v.e_ti    = 3'(eti);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic a, input logic sv, input logic [DATA_W-1:0] smp,
                        input logic tr, input logic [ADDR_W-1:0] po, input logic rd);
      arm          = a;
      sample_valid = sv;
      sample_in    = smp;
      trig_in      = tr;
      post_count   = po;
      rd_en        = rd;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset values
      #12;
      chk("rst state", 32'(state), 32'd0);
      chk("rst count", 32'(count), 32'd0);
      chk("rst trig_index", 32'(trig_index), 32'd0);
      chk("rst rd_data", rd_data, 32'd0);
      chk("rst rd_valid", 32'(rd_valid), 32'd0);
      chk("rst rd_last", 32'(rd_last), 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;

      //    arm sv smp   tr po rd | st cnt rv rl data | cti ti
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  0, 0, 0, 0, 0,     0, 0));
      // Basic capture, post_count=1
      tbl.push_back(mk(1, 0, 0,    1, 0, 0,  1, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 'hA,  0, 1, 1,  1, 1, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 'hB,  1, 1, 0,  2, 2, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 0, 'hEE, 1, 0, 0,  2, 2, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 'hC,  0, 0, 0,  3, 3, 0, 0, 0,     1, 1));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  3, 3, 1, 0, 'hA,   1, 1));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  3, 3, 1, 0, 'hB,   1, 1));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  0, 3, 1, 1, 'hC,   1, 1));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  0, 3, 0, 0, 0,     1, 1));
      // Trigger qualification, post_count=0
      tbl.push_back(mk(1, 0, 0,    0, 0, 0,  1, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 0, 'h99, 1, 0, 0,  1, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 5,    0, 0, 0,  1, 1, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 6,    0, 0, 0,  1, 2, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 0, 'h98, 1, 0, 0,  1, 2, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 7,    1, 0, 0,  3, 3, 0, 0, 0,     1, 2));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  3, 3, 1, 0, 5,     1, 2));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  3, 3, 1, 0, 6,     1, 2));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  0, 3, 1, 1, 7,     1, 2));
      // Trigger on first sample, post_count=0
      tbl.push_back(mk(1, 0, 0,    0, 0, 0,  1, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 'hFF, 1, 0, 0,  3, 1, 0, 0, 0,     1, 0));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  0, 1, 1, 1, 'hFF,  1, 0));
      // arm in DONE wins over a same-cycle read
      tbl.push_back(mk(1, 0, 0,    0, 0, 0,  1, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 1, 'h55, 1, 0, 0,  3, 1, 0, 0, 0,     1, 0));
      tbl.push_back(mk(1, 0, 0,    0, 0, 1,  1, 0, 0, 0, 0,     0, 0));
      tbl.push_back(mk(0, 0, 0,    0, 0, 1,  1, 0, 0, 0, 0,     0, 0));

      foreach (tbl[i]) begin
         drive(tbl[i].arm, tbl[i].sv, tbl[i].smp, tbl[i].trig, tbl[i].post, tbl[i].rd);
         step();
         chk($sformatf("v%0d state", i), 32'(state), 32'(tbl[i].e_state));
         chk($sformatf("v%0d count", i), 32'(count), 32'(tbl[i].e_count));
         chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rv));
         chk($sformatf("v%0d rd_last", i), 32'(rd_last), 32'(tbl[i].e_rl));
         if (tbl[i].e_rv) chk($sformatf("v%0d rd_data", i), rd_data, tbl[i].e_data);
         if (tbl[i].chk_ti) chk($sformatf("v%0d trig_index", i), 32'(trig_index), 32'(tbl[i].e_ti));
      end

      // Wrap: samples 1..20, trigger on 15, post_count=3; 19 and 20 arrive in DONE
      drive(1, 0, 0, 0, 0, 0);
      step();
      for (int s = 1; s <= 20; s++) begin
         drive(0, 1, 32'(s), s == 15, 3'd3, 0);
         step();
         chk($sformatf("wrap s%0d state", s), 32'(state),
             (s < 15) ? 32'd1 : (s < 18) ? 32'd2 : 32'd3);
         chk($sformatf("wrap s%0d count", s), 32'(count), (s < 8) ? 32'(s) : 32'd8);
      end
      chk("wrap trig_index", 32'(trig_index), 32'd4);
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         step();
         chk($sformatf("wrap rd%0d valid", i), 32'(rd_valid), (i < 8) ? 32'd1 : 32'd0);
         chk($sformatf("wrap rd%0d last", i), 32'(rd_last), (i == 7) ? 32'd1 : 32'd0);
         chk($sformatf("wrap rd%0d state", i), 32'(state), (i < 7) ? 32'd3 : 32'd0);
         if (i < 8) chk($sformatf("wrap rd%0d data", i), rd_data, 32'(11 + i));
      end

      // Asynchronous reset while in POST after 4 samples
      drive(1, 0, 0, 0, 0, 0);
      step();
      drive(0, 1, 32'h21, 1, 3'd5, 0);
      step();
      for (int s = 0; s < 3; s++) begin
         drive(0, 1, 32'(32'h22 + s), 0, 3'd0, 0);
         step();
      end
      chk("pre-reset state", 32'(state), 32'd2);
      chk("pre-reset count", 32'(count), 32'd4);
      drive(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      #2;
      chk("async rst state", 32'(state), 32'd0);
      chk("async rst count", 32'(count), 32'd0);
      chk("async rst rd_valid", 32'(rd_valid), 32'd0);
      chk("async rst rd_data", rd_data, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 0, 1);
         step();
         chk($sformatf("post-rst rd%0d valid", i), 32'(rd_valid), 32'd0);
         chk($sformatf("post-rst rd%0d state", i), 32'(state), 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
